// File: rtl/seg7_pkg.sv
// Shared definitions for seven-segment display blocks.
// Patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Zero latency, no handshake.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode display driver with a frame-synchronous double buffer.
// Outputs are registered (1 cycle after counter/index state); load_ready low while a value is pending.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int GUARD_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        blank_lz,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_val,
    input  logic [3:0]  load_dp,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0]         cnt;
    digit_idx_t            idx;
    logic [15:0]           disp_val;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic [15:0]           pend_val;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic                  pend_full;

    logic       slot_end;
    logic       frame_end;
    logic       xfer;
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic [6:0] dec_seg;
    logic       guard;
    logic       blanked;
    logic       lz3, lz2, lz1;
    logic [3:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;

    assign slot_end   = (cnt == CW'(TICK_DIV - 1));
    assign frame_end  = slot_end && (idx == digit_idx_t'(NUM_DIGITS - 1));
    assign load_ready = !pend_full;
    assign xfer       = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending is only promoted at a frame boundary so a frame is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
            disp_val  <= '0;
            disp_dp   <= '0;
        end else if (xfer) begin
            pend_val  <= load_val;
            pend_dp   <= load_dp;
            pend_full <= 1'b1;
        end else if (frame_end && pend_full) begin
            disp_val  <= pend_val;
            disp_dp   <= pend_dp;
            pend_full <= 1'b0;
        end
    end

    assign cur_nib = disp_val[{idx, 2'b00} +: 4];
    assign cur_dp  = disp_dp[idx];
    assign guard   = (cnt < CW'(GUARD_CYC));

    assign lz3 = blank_lz && (disp_val[15:12] == 4'h0);
    assign lz2 = lz3 && (disp_val[11:8] == 4'h0);
    assign lz1 = lz2 && (disp_val[7:4] == 4'h0);

    always_comb begin
        blanked = 1'b0;
        case (idx)
            2'd3:    blanked = lz3;
            2'd2:    blanked = lz2;
            2'd1:    blanked = lz1;
            default: blanked = 1'b0;
        endcase
    end

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // A blanked digit keeps its anode on only to show a lit decimal point.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (enable && !guard) begin
            if (!blanked) begin
                an_d  = ~(4'b0001 << idx);
                seg_d = dec_seg;
                dp_d  = ~cur_dp;
            end else if (cur_dp) begin
                an_d  = ~(4'b0001 << idx);
                dp_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule
